// File: rtl/restoring_divider_pkg.sv
// Shared types for the sequential restoring divider.
package div_pkg;

  // Controller states; codes 5..7 are unused and fall back to IDLE.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    SUB   = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/restoring_divider_if.sv
// Request/result bundle of the restoring divider.
// The master issues set/a/b and observes results; the slave is the divider.
interface restoring_divider_if #(
  parameter int N = 4
);

  logic         set;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] q;
  logic [N-1:0] rem;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  modport master (
    output set, a, b,
    input  q, rem, busy, done, div_by_zero
  );

  modport slave (
    input  set, a, b,
    output q, rem, busy, done, div_by_zero
  );

endinterface

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one shift step and one
// compare/subtract step per quotient bit, so 2N+3 edges from the edge that
// accepts set to the done pulse (3 edges for a zero divisor).
module restoring_divider
  import div_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                rst,
  restoring_divider_if.slave  bus
);

  localparam int             CW         = $clog2(N + 1);
  localparam logic [N-1:0]   ZDIV_Q     = {N{1'b1}};
  localparam logic [CW-1:0]  COUNT_INIT = CW'(N);
  localparam logic [CW-1:0]  COUNT_ONE  = CW'(1);

  state_t         state_r;
  state_t         state_s;

  // Working registers: partial remainder, dividend/quotient shifter, divisor.
  logic [N:0]     a_r;
  logic [N-1:0]   q_sh_r;
  logic [N-1:0]   m_r;
  logic [CW-1:0]  count_r;
  logic           dz_r;

  // Result registers driven onto the interface.
  logic [N-1:0]   q_r;
  logic [N-1:0]   rem_r;
  logic           done_r;
  logic           busy_r;
  logic           div_by_zero_r;

  logic [N:0]     diff_s;
  logic           no_borrow_s;

  // Next-state decode of the controller.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.set) begin
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (bus.b == {N{1'b0}}) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      SHIFT: begin
        state_s = SUB;
      end
      SUB: begin
        if (count_r == {CW{1'b0}}) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Trial subtraction of the divisor from the partial remainder.
  always_comb begin
    diff_s      = a_r - {1'b0, m_r};
    no_borrow_s = (a_r >= {1'b0, m_r});
  end

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath: operand capture, shift, and conditional subtract/restore.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= {(N+1){1'b0}};
      q_sh_r  <= {N{1'b0}};
      m_r     <= {N{1'b0}};
      count_r <= {CW{1'b0}};
      dz_r    <= 1'b0;
    end else begin
      case (state_r)
        LOAD: begin
          a_r     <= {(N+1){1'b0}};
          q_sh_r  <= bus.a;
          m_r     <= bus.b;
          count_r <= COUNT_INIT;
          dz_r    <= (bus.b == {N{1'b0}});
        end
        SHIFT: begin
          // A[N] is always 0 before a shift, so dropping it loses nothing.
          {a_r, q_sh_r} <= {a_r[N-1:0], q_sh_r, 1'b0};
          count_r       <= count_r - COUNT_ONE;
        end
        SUB: begin
          if (no_borrow_s) begin
            a_r       <= diff_s;
            q_sh_r[0] <= 1'b1;
          end else begin
            a_r    <= a_r;
            q_sh_r <= q_sh_r;
          end
        end
        default: begin
          a_r     <= a_r;
          q_sh_r  <= q_sh_r;
          m_r     <= m_r;
          count_r <= count_r;
          dz_r    <= dz_r;
        end
      endcase
    end
  end

  // Result registers, busy flag and the one-cycle done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r           <= {N{1'b0}};
      rem_r         <= {N{1'b0}};
      div_by_zero_r <= 1'b0;
      done_r        <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      done_r <= (state_r == DONE);
      busy_r <= (state_s != IDLE);
      if (state_r == DONE) begin
        if (dz_r) begin
          // No shifts happened, so the shifter still holds the dividend.
          q_r           <= ZDIV_Q;
          rem_r         <= q_sh_r;
          div_by_zero_r <= 1'b1;
        end else begin
          q_r           <= q_sh_r;
          rem_r         <= a_r[N-1:0];
          div_by_zero_r <= 1'b0;
        end
      end else begin
        q_r           <= q_r;
        rem_r         <= rem_r;
        div_by_zero_r <= div_by_zero_r;
      end
    end
  end

  assign bus.q           = q_r;
  assign bus.rem         = rem_r;
  assign bus.done        = done_r;
  assign bus.busy        = busy_r;
  assign bus.div_by_zero = div_by_zero_r;

endmodule
